// File: rtl/exec_pkg.sv
// Shared constants for the execute stage: opcodes, FSM states and default width.
package exec_pkg;

    localparam int DEF_WIDTH = 8;

    localparam logic [3:0] OP_ADD    = 4'd0;
    localparam logic [3:0] OP_ADDC   = 4'd1;
    localparam logic [3:0] OP_SUB    = 4'd2;
    localparam logic [3:0] OP_SUBC   = 4'd3;
    localparam logic [3:0] OP_AND    = 4'd4;
    localparam logic [3:0] OP_OR     = 4'd5;
    localparam logic [3:0] OP_XOR    = 4'd6;
    localparam logic [3:0] OP_SHL    = 4'd7;
    localparam logic [3:0] OP_SHR    = 4'd8;
    localparam logic [3:0] OP_ROL    = 4'd9;
    localparam logic [3:0] OP_ROR    = 4'd10;
    localparam logic [3:0] OP_MUL    = 4'd11;
    localparam logic [3:0] OP_PASS_B = 4'd12;

    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } exec_state_t;

endpackage

// File: rtl/exec_mul_seq.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
module exec_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic               running;

    always_comb begin
        acc_next = acc;
        if (mplier[0]) begin
            acc_next = acc + mcand;
        end
    end

    // The final step's sum is exposed combinationally so the caller can
    // register it on the same edge that retires the operation.
    assign busy    = running;
    assign done    = running && (count == CW'(WIDTH - 1));
    assign product = acc_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            running <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
        end else if (start && !running) begin
            running <= 1'b1;
            acc     <= '0;
            mcand   <= {{WIDTH{1'b0}}, a};
            mplier  <= b;
            count   <= '0;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_stage_mc.sv
// Execute stage: forwarding, single-cycle ALU and a multi-cycle multiplier behind a stall.
module exec_stage_mc
    import exec_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] r1,
    input  logic [WIDTH-1:0] r2,
    input  logic [WIDTH-1:0] disp_const,
    input  logic             alu_b_sel,
    input  logic [1:0]       fwd_a_sel,
    input  logic [1:0]       fwd_b_sel,
    input  logic [WIDTH-1:0] ex_mem_result,
    input  logic [WIDTH-1:0] mem_wb_result,
    input  logic [3:0]       alu_op,
    input  logic [SHW-1:0]   shift_count,
    input  logic             z_en,
    input  logic             c_en,
    output logic             stall,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_out,
    output logic             z_flag,
    output logic             c_flag
);

    exec_state_t state, state_next;

    logic [WIDTH-1:0]   b_pre, op_a, op_b;
    logic               accept, is_mul, mul_start;
    logic               mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic               mul_z_en, mul_c_en;

    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     sum;
    logic               c_next, c_upd, z_upd;
    logic [WIDTH:0]     shl_t, shr_t;
    logic [2*WIDTH-1:0] rol_t, ror_t;
    logic [SHW-1:0]     rot_amt;

    // Forwarding sits after the immediate select, so it overrides the immediate.
    always_comb begin
        b_pre = alu_b_sel ? disp_const : r2;
        case (fwd_a_sel)
            2'b01:   op_a = ex_mem_result;
            2'b10:   op_a = mem_wb_result;
            default: op_a = r1;
        endcase
        case (fwd_b_sel)
            2'b01:   op_b = ex_mem_result;
            2'b10:   op_b = mem_wb_result;
            default: op_b = b_pre;
        endcase
    end

    assign stall     = (state == MUL_BUSY);
    assign accept    = in_valid && !stall;
    assign is_mul    = (alu_op == OP_MUL);
    assign mul_start = accept && is_mul;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (mul_start) state_next = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    exec_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    // An extra zero bit on the shifted-out side captures the last bit lost.
    always_comb begin
        rot_amt = SHW'(shift_count % WIDTH);
        shl_t   = {1'b0, op_a} << shift_count;
        shr_t   = {op_a, 1'b0} >> shift_count;
        rol_t   = {op_a, op_a} << rot_amt;
        ror_t   = {op_a, op_a} >> rot_amt;
    end

    always_comb begin
        res    = '0;
        sum    = '0;
        c_next = 1'b0;
        c_upd  = 1'b1;
        z_upd  = 1'b1;
        case (alu_op)
            OP_ADD: begin
                sum    = {1'b0, op_a} + {1'b0, op_b};
                res    = sum[WIDTH-1:0];
                c_next = sum[WIDTH];
            end
            OP_ADDC: begin
                sum    = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, c_flag};
                res    = sum[WIDTH-1:0];
                c_next = sum[WIDTH];
            end
            OP_SUB: begin
                sum    = {1'b0, op_a} - {1'b0, op_b};
                res    = sum[WIDTH-1:0];
                c_next = sum[WIDTH];
            end
            OP_SUBC: begin
                sum    = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, c_flag};
                res    = sum[WIDTH-1:0];
                c_next = sum[WIDTH];
            end
            OP_AND:    res = op_a & op_b;
            OP_OR:     res = op_a | op_b;
            OP_XOR:    res = op_a ^ op_b;
            OP_SHL: begin
                res    = shl_t[WIDTH-1:0];
                c_next = shl_t[WIDTH];
            end
            OP_SHR: begin
                res    = shr_t[WIDTH:1];
                c_next = shr_t[0];
            end
            OP_ROL: begin
                res   = rol_t[2*WIDTH-1:WIDTH];
                c_upd = 1'b0;
            end
            OP_ROR: begin
                res   = ror_t[WIDTH-1:0];
                c_upd = 1'b0;
            end
            OP_PASS_B: res = op_b;
            default: begin
                // Reserved opcodes, and MUL which retires later through the multiplier.
                c_upd = 1'b0;
                z_upd = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            alu_out   <= '0;
            z_flag    <= 1'b0;
            c_flag    <= 1'b0;
            mul_z_en  <= 1'b0;
            mul_c_en  <= 1'b0;
        end else begin
            state     <= state_next;
            out_valid <= 1'b0;
            if (state == MUL_BUSY) begin
                if (mul_done) begin
                    out_valid <= 1'b1;
                    alu_out   <= mul_product[WIDTH-1:0];
                    if (mul_z_en) z_flag <= (mul_product[WIDTH-1:0] == '0);
                    if (mul_c_en) c_flag <= |mul_product[2*WIDTH-1:WIDTH];
                end
            end else if (accept) begin
                if (is_mul) begin
                    mul_z_en <= z_en;
                    mul_c_en <= c_en;
                end else begin
                    out_valid <= 1'b1;
                    alu_out   <= res;
                    if (z_en && z_upd) z_flag <= (res == '0);
                    if (c_en && c_upd) c_flag <= c_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_exec_stage_mc.sv
// Directed checks of the execute stage at WIDTH=8 with hand-computed expectations.
module tb_exec_stage_mc;
    import exec_pkg::*;

    localparam int W = 8;
    localparam int S = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] r1, r2, disp_const, ex_mem_result, mem_wb_result;
    logic         alu_b_sel;
    logic [1:0]   fwd_a_sel, fwd_b_sel;
    logic [3:0]   alu_op;
    logic [S-1:0] shift_count;
    logic         z_en, c_en;
    logic         stall, out_valid, z_flag, c_flag;
    logic [W-1:0] alu_out;

    int total = 0;
    int bad   = 0;

    exec_stage_mc #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .r1            (r1),
        .r2            (r2),
        .disp_const    (disp_const),
        .alu_b_sel     (alu_b_sel),
        .fwd_a_sel     (fwd_a_sel),
        .fwd_b_sel     (fwd_b_sel),
        .ex_mem_result (ex_mem_result),
        .mem_wb_result (mem_wb_result),
        .alu_op        (alu_op),
        .shift_count   (shift_count),
        .z_en          (z_en),
        .c_en          (c_en),
        .stall         (stall),
        .out_valid     (out_valid),
        .alu_out       (alu_out),
        .z_flag        (z_flag),
        .c_flag        (c_flag)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [S-1:0] sc, input logic ce, input logic ze);
        in_valid    = 1'b1;
        alu_op      = op;
        r1          = a;
        r2          = b;
        shift_count = sc;
        c_en        = ce;
        z_en        = ze;
        alu_b_sel   = 1'b0;
        fwd_a_sel   = 2'b00;
        fwd_b_sel   = 2'b00;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        drive(OP_ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0);
        in_valid = 1'b0;
        disp_const = 8'h00; ex_mem_result = 8'h00; mem_wb_result = 8'h00;
        step(); step();
        rst = 1'b0;
        total++;
        if ({stall, out_valid, alu_out, z_flag, c_flag} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got stall=%b ov=%b out=%h z=%b c=%b want 0 0 00 0 0",
                     stall, out_valid, alu_out, z_flag, c_flag);
        end
    endtask

    task automatic test_add_chain();
        drive(OP_ADD, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({out_valid, alu_out, c_flag, z_flag} !== {1'b1, 8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL add_ff_01: got ov=%b out=%h c=%b z=%b want 1 00 1 1", out_valid, alu_out, c_flag, z_flag);
        end
        drive(OP_ADDC, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({out_valid, alu_out, c_flag, z_flag} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL addc: got ov=%b out=%h c=%b z=%b want 1 03 0 0", out_valid, alu_out, c_flag, z_flag);
        end
        in_valid = 1'b0;
        step();
        total++;
        if ({out_valid, alu_out} !== {1'b0, 8'h03}) begin
            bad++;
            $display("FAIL idle_hold: got ov=%b out=%h want 0 03", out_valid, alu_out);
        end
    endtask

    task automatic test_sub();
        drive(OP_SUB, 8'h05, 8'h07, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'hFE, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL sub_borrow: got out=%h c=%b z=%b want fe 1 0", alu_out, c_flag, z_flag);
        end
        drive(OP_SUBC, 8'h10, 8'h01, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'h0E, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL subc: got out=%h c=%b z=%b want 0e 0 0", alu_out, c_flag, z_flag);
        end
        drive(OP_XOR, 8'hA5, 8'hA5, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'h00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL xor_zero: got out=%h c=%b z=%b want 00 0 1", alu_out, c_flag, z_flag);
        end
    endtask

    task automatic test_forwarding();
        drive(OP_ADD, 8'h10, 8'h77, 3'd0, 1'b0, 1'b0);
        fwd_a_sel = 2'b01; ex_mem_result = 8'h20;
        alu_b_sel = 1'b1;  disp_const    = 8'h05;
        fwd_b_sel = 2'b10; mem_wb_result = 8'h03;
        step();
        total++;
        if ({out_valid, alu_out} !== {1'b1, 8'h23}) begin
            bad++;
            $display("FAIL fwd_add: got ov=%b out=%h want 1 23", out_valid, alu_out);
        end
        drive(OP_PASS_B, 8'h00, 8'h77, 3'd0, 1'b0, 1'b0);
        alu_b_sel = 1'b1; fwd_b_sel = 2'b11;
        step();
        total++;
        if (alu_out !== 8'h05) begin
            bad++;
            $display("FAIL imm_pass: got out=%h want 05", alu_out);
        end
    endtask

    task automatic test_mul();
        drive(OP_MUL, 8'h13, 8'h0F, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_no_early_valid: got ov=%b want 0", out_valid);
        end
        // Upstream presents an ADD while the stage is busy; it must wait.
        drive(OP_ADD, 8'h05, 8'h06, 3'd0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            total++;
            if (stall !== 1'b1) begin
                bad++;
                $display("FAIL mul_stall_t%0d: got stall=%b want 1", i, stall);
            end
            step();
        end
        total++;
        if ({stall, out_valid, alu_out, c_flag, z_flag} !== {1'b0, 1'b1, 8'h1D, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL mul_result: got stall=%b ov=%b out=%h c=%b z=%b want 0 1 1d 1 0",
                     stall, out_valid, alu_out, c_flag, z_flag);
        end
        step();
        total++;
        if ({out_valid, alu_out} !== {1'b1, 8'h0B}) begin
            bad++;
            $display("FAIL held_add: got ov=%b out=%h want 1 0b", out_valid, alu_out);
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mul();
        drive(OP_MUL, 8'h13, 8'h0F, 3'd0, 1'b1, 1'b1);
        step();
        in_valid = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++;
        if ({stall, out_valid, z_flag, c_flag} !== 4'b0000) begin
            bad++;
            $display("FAIL rst_mid_mul: got stall=%b ov=%b z=%b c=%b want 0 0 0 0", stall, out_valid, z_flag, c_flag);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            total++;
            if (out_valid !== 1'b0 || stall !== 1'b0) begin
                bad++;
                $display("FAIL aborted_mul_cyc%0d: got ov=%b stall=%b want 0 0", i, out_valid, stall);
            end
        end
    endtask

    task automatic test_shift_rotate();
        drive(OP_SHL, 8'h81, 8'h00, 3'd1, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'h02, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL shl: got out=%h c=%b z=%b want 02 1 0", alu_out, c_flag, z_flag);
        end
        drive(OP_ROR, 8'h01, 8'h00, 3'd3, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag} !== {8'h20, 1'b1}) begin
            bad++;
            $display("FAIL ror: got out=%h c=%b want 20 1", alu_out, c_flag);
        end
        drive(OP_ROL, 8'h81, 8'h00, 3'd2, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag} !== {8'h06, 1'b1}) begin
            bad++;
            $display("FAIL rol: got out=%h c=%b want 06 1", alu_out, c_flag);
        end
        drive(OP_SHL, 8'h81, 8'h00, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag} !== {8'h81, 1'b0}) begin
            bad++;
            $display("FAIL shl_zero: got out=%h c=%b want 81 0", alu_out, c_flag);
        end
        drive(OP_SHR, 8'h01, 8'h00, 3'd1, 1'b1, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'h00, 1'b1, 1'b1}) begin
            bad++;
            $display("FAIL shr: got out=%h c=%b z=%b want 00 1 1", alu_out, c_flag, z_flag);
        end
        // Seed a non-zero result so the reserved op's zero output cannot move Z.
        drive(OP_OR, 8'h40, 8'h02, 3'd0, 1'b0, 1'b1);
        step();
        drive(4'd15, 8'h55, 8'h66, 3'd0, 1'b1, 1'b1);
        step();
        total++;
        if ({out_valid, alu_out, z_flag, c_flag} !== {1'b1, 8'h00, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reserved: got ov=%b out=%h z=%b c=%b want 1 00 0 1", out_valid, alu_out, z_flag, c_flag);
        end
    endtask

    task automatic test_enable_gating();
        drive(OP_ADD, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1);
        step();
        total++;
        if ({z_flag, c_flag} !== {1'b1, 1'b1}) begin
            bad++;
            $display("FAIL zero_add_c_held: got z=%b c=%b want 1 1", z_flag, c_flag);
        end
        drive(OP_ADD, 8'hF0, 8'h20, 3'd0, 1'b0, 1'b1);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'h10, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL gate_c: got out=%h c=%b z=%b want 10 1 0", alu_out, c_flag, z_flag);
        end
        drive(OP_SUB, 8'h07, 8'h07, 3'd0, 1'b1, 1'b0);
        step();
        total++;
        if ({alu_out, c_flag, z_flag} !== {8'h00, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL gate_z: got out=%h c=%b z=%b want 00 0 0", alu_out, c_flag, z_flag);
        end
        in_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_add_chain();
        test_sub();
        test_forwarding();
        test_mul();
        test_reset_mul();
        test_shift_rotate();
        test_enable_gating();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
